// File: rtl/life_step_sequencer.sv
// Conway's Life generation engine over a 128x32 toroidal grid held in external block memory.
// Streams rows through a three-row window; the CPU port pre-empts the engine on any cycle it requests.
module life_step_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen_count,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [6:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        mem_we,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [3:0] {
    IDLE, RD_LAST, CAP_LAST, RD_FIRST, CAP_FIRST, STEP_RD, STEP_CAP, STEP_WR, DONE
  } state_t;

  state_t      state;
  logic [31:0] prev, cur, next_row, row0_save;
  logic [6:0]  r;
  logic        last_row;
  logic        eng_wr;
  logic [6:0]  eng_addr;
  logic [31:0] new_row;

  assign last_row = (r == 7'd127);

  function automatic logic [31:0] life_row(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    logic [31:0] res;
    logic [31:0] a_l, a_r, b_l, b_r, c_l, c_r;
    logic [3:0]  n;
    // x_l bit i holds column i-1, x_r bit i holds column i+1 (columns wrap)
    a_l = {a[30:0], a[31]};
    a_r = {a[0], a[31:1]};
    b_l = {b[30:0], b[31]};
    b_r = {b[0], b[31:1]};
    c_l = {c[30:0], c[31]};
    c_r = {c[0], c[31:1]};
    res = '0;
    for (int i = 0; i < 32; i++) begin
      n = 4'(a_l[i]) + 4'(a[i]) + 4'(a_r[i]) + 4'(b_l[i]) + 4'(b_r[i])
        + 4'(c_l[i]) + 4'(c[i]) + 4'(c_r[i]);
      res[i] = (n == 4'd3) || (b[i] && (n == 4'd2));
    end
    return res;
  endfunction

  assign new_row = life_row(prev, cur, next_row);

  always_comb begin
    eng_wr   = 1'b0;
    eng_addr = '0;
    case (state)
      RD_LAST:  eng_addr = 7'd127;
      RD_FIRST: eng_addr = 7'd0;
      STEP_RD:  if (!last_row) eng_addr = r + 7'd1;
      STEP_WR: begin
        eng_wr   = 1'b1;
        eng_addr = r;
      end
      default: ;
    endcase
  end

  // CPU owns the memory port whenever it asks; the engine only writes when not being reset.
  assign mem_addr  = cpu_req ? cpu_addr  : eng_addr;
  assign mem_we    = cpu_req ? cpu_we    : (eng_wr & ~rst);
  assign mem_wdata = cpu_req ? cpu_wdata : new_row;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_ack   <= 1'b0;
      gen_count <= '0;
      prev      <= '0;
      cur       <= '0;
      next_row  <= '0;
      row0_save <= '0;
      r         <= '0;
    end else begin
      cpu_ack <= cpu_req;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RD_LAST;
          busy  <= 1'b1;
        end
        RD_LAST:  if (!cpu_req) state <= CAP_LAST;
        CAP_LAST: begin
          prev  <= mem_rdata;
          state <= RD_FIRST;
        end
        RD_FIRST: if (!cpu_req) state <= CAP_FIRST;
        CAP_FIRST: begin
          cur       <= mem_rdata;
          row0_save <= mem_rdata;
          r         <= '0;
          state     <= STEP_RD;
        end
        STEP_RD: if (last_row || !cpu_req) state <= STEP_CAP;
        STEP_CAP: begin
          // row 0 was overwritten long ago, so the wrap neighbour comes from the saved copy
          next_row <= last_row ? row0_save : mem_rdata;
          state    <= STEP_WR;
        end
        STEP_WR: if (!cpu_req) begin
          prev <= cur;
          cur  <= next_row;
          if (last_row) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            r     <= r + 7'd1;
            state <= STEP_RD;
          end
        end
        DONE: begin
          gen_count <= gen_count + 16'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
